// File: rtl/sram_ingress_framer.sv
// Packet ingress buffer: validates a length header, stores header plus payload in a circular
// SRAM, and exposes only fully received packets to a first-word-fall-through read port.
module sram_ingress_framer #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned LEN_W  = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_sop,
    input  logic                      wr_vld,
    input  logic                      wr_eop,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      out_ready,
    output logic                      out_vld,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [DATA_W-1:0]         out_data,
    output logic                      err_drop,
    output logic [7:0]                drop_cnt,
    output logic [$clog2(DEPTH):0]    free_words
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {StIdle, StHdr, StPay, StDrop} state_t;

    state_t            state_q;
    logic [PW-1:0]     wr_ptr_q, commit_ptr_q, rd_ptr_q;
    logic [LEN_W-1:0]  pay_len_q, pay_cnt_q, rd_cnt_q;
    logic              pay_ovf_q;
    logic              err_drop_q;
    logic [7:0]        drop_cnt_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [LEN_W-1:0]  hdr_len;
    logic [PW-1:0]     fill;
    logic              word_in;
    logic              hdr_ok;
    logic              pay_ok;
    logic              mem_we;
    logic              drop_evt;
    logic              rd_xfer;
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        hdr_len    = wr_data[7 +: LEN_W];
        fill       = wr_ptr_q - rd_ptr_q;
        free_words = PW'(DEPTH) - fill;
        // A plain data word: sop and eop cycles never carry payload.
        word_in    = wr_vld && !wr_sop && !wr_eop;
        // Whole packet must fit at header time, so PAY can never overrun the reader.
        hdr_ok     = (hdr_len != '0) && (32'(hdr_len) <= DEPTH - 1)
                     && (32'(hdr_len) + 32'd1 <= 32'(free_words));
        pay_ok     = !pay_ovf_q && (pay_cnt_q == pay_len_q);
        mem_we     = ((state_q == StHdr) && word_in && hdr_ok)
                     || ((state_q == StPay) && word_in && (pay_cnt_q != pay_len_q));
        drop_evt   = 1'b0;
        unique case (state_q)
            StHdr:   drop_evt = wr_sop || wr_eop || (wr_vld && !hdr_ok);
            StPay:   drop_evt = wr_sop || (wr_eop && !pay_ok);
            default: drop_evt = 1'b0;
        endcase
    end

    always_comb begin
        rd_word  = mem[rd_ptr_q[AW-1:0]];
        out_vld  = (rd_ptr_q != commit_ptr_q);
        out_data = out_vld ? rd_word : '0;
        out_sop  = out_vld && (rd_cnt_q == '0);
        out_eop  = out_vld && (rd_cnt_q == LEN_W'(1));
        rd_xfer  = out_vld && out_ready;
        err_drop = err_drop_q;
        drop_cnt = drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            pay_len_q    <= '0;
            pay_cnt_q    <= '0;
            pay_ovf_q    <= 1'b0;
            err_drop_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            err_drop_q <= drop_evt;
            if (drop_evt && (drop_cnt_q != 8'hff)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            if (mem_we) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (wr_sop) state_q <= StHdr;
                end
                StHdr: begin
                    if (wr_sop) begin
                        state_q <= StHdr;
                    end else if (wr_eop) begin
                        state_q <= StIdle;
                    end else if (wr_vld) begin
                        state_q   <= hdr_ok ? StPay : StDrop;
                        pay_len_q <= hdr_len;
                        pay_cnt_q <= '0;
                        pay_ovf_q <= 1'b0;
                    end
                end
                StPay: begin
                    if (wr_sop) begin
                        state_q  <= StHdr;
                        wr_ptr_q <= commit_ptr_q;
                    end else if (wr_eop) begin
                        state_q <= StIdle;
                        if (pay_ok) commit_ptr_q <= wr_ptr_q;
                        else        wr_ptr_q     <= commit_ptr_q;
                    end else if (wr_vld) begin
                        if (pay_cnt_q != pay_len_q) pay_cnt_q <= pay_cnt_q + LEN_W'(1);
                        else                        pay_ovf_q <= 1'b1;
                    end
                end
                StDrop: begin
                    // Already counted on entry; a new sop just restarts framing.
                    if (wr_sop)      state_q <= StHdr;
                    else if (wr_eop) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            rd_cnt_q <= '0;
        end else if (rd_xfer) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
            rd_cnt_q <= out_sop ? rd_word[7 +: LEN_W] : rd_cnt_q - LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_sram_ingress_framer.sv
// Directed bench for sram_ingress_framer: stimulus pushes expected output words into a queue,
// a negedge monitor pops and compares on every accepted output word.
module tb_sram_ingress_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_sop = 1'b0, wr_vld = 1'b0, wr_eop = 1'b0;
    logic [63:0] wr_data = '0;
    logic        out_ready = 1'b0;
    logic        out_vld, out_sop, out_eop, err_drop;
    logic [63:0] out_data;
    logic [7:0]  drop_cnt;
    logic [5:0]  free_words;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   pulses = 0;
    int   exp_pulses = 0;
    int   exp_cnt = 0;

    sram_ingress_framer #(.DATA_W(64), .DEPTH(32), .LEN_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_sop(wr_sop), .wr_vld(wr_vld), .wr_eop(wr_eop), .wr_data(wr_data),
        .out_ready(out_ready), .out_vld(out_vld), .out_sop(out_sop), .out_eop(out_eop),
        .out_data(out_data), .err_drop(err_drop), .drop_cnt(drop_cnt), .free_words(free_words)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk_hdr(input int dest, input int pri, input int len);
        return 64'hC0DE_0000_0000_0000 | 64'(dest & 15) | (64'(pri & 7) << 4)
               | (64'(len & 127) << 7);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && err_drop) pulses++;
        if (rst_n && out_vld && out_ready) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_out: got %0h, expected no output", out_data);
            end else begin
                e = q.pop_front();
                if ({out_sop, out_eop, out_data} !== {e.sop, e.eop, e.data}) begin
                    mismatched++;
                    $display("FAIL out_word: got sop=%0b eop=%0b data=%0h, expected sop=%0b eop=%0b data=%0h",
                             out_sop, out_eop, out_data, e.sop, e.eop, e.data);
                end
            end
        end
    end

    task automatic drive(input logic sop, input logic vld, input logic eop, input logic [63:0] d);
        wr_sop = sop; wr_vld = vld; wr_eop = eop; wr_data = d;
        @(posedge clk); #1;
        wr_sop = 1'b0; wr_vld = 1'b0; wr_eop = 1'b0;
    endtask

    task automatic send_pkt(input int dest, input int len, input int nw, input logic [63:0] base,
                            input bit good);
        exp_t e;
        logic [63:0] h;
        h = mk_hdr(dest, 2, len);
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b0, h);
        for (int i = 0; i < nw; i++) drive(1'b0, 1'b1, 1'b0, base + 64'(i));
        drive(1'b0, 1'b0, 1'b1, 64'hDEAD);
        if (good) begin
            e = {1'b1, 1'b0, h};
            q.push_back(e);
            for (int i = 0; i < len; i++) begin
                e = {1'b0, (i == len - 1), base + 64'(i)};
                q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (q.size() == 0 && !out_vld) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check({name, "_left"}, 64'(q.size()), 64'd0);
        check({name, "_vld"}, 64'(out_vld), 64'd0);
    endtask

    task automatic settle_drops(input string name);
        repeat (2) begin @(posedge clk); #1; end
        check({name, "_cnt"}, 64'(drop_cnt), 64'(exp_cnt));
        check({name, "_pulses"}, 64'(pulses), 64'(exp_pulses));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", 64'(out_vld), 64'd0);
        check("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
        check("rst_err", 64'(err_drop), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_cnt", 64'(drop_cnt), 64'd0);
        check("rst_free", 64'(free_words), 64'd32);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal packet, dest 5, L=4
        out_ready = 1'b1;
        send_pkt(5, 4, 4, 64'h100, 1'b1);
        check("lat_vld", 64'(out_vld), 64'd1);
        check("lat_sop", 64'(out_sop), 64'd1);
        wait_drain("nominal");
        check("nominal_free", 64'(free_words), 64'd32);
        settle_drops("nominal");

        // Short payload
        send_pkt(1, 4, 3, 64'h200, 1'b0);
        exp_cnt++; exp_pulses++;
        settle_drops("short");
        check("short_free", 64'(free_words), 64'd32);
        check("short_vld", 64'(out_vld), 64'd0);

        // Invalid lengths 0 and 40
        send_pkt(2, 0, 0, 64'h0, 1'b0);
        send_pkt(2, 40, 3, 64'h300, 1'b0);
        exp_cnt += 2; exp_pulses += 2;
        settle_drops("badlen");
        check("badlen_vld", 64'(out_vld), 64'd0);

        // Fill under backpressure, then overflow attempt
        out_ready = 1'b0;
        send_pkt(3, 15, 15, 64'h1000, 1'b1);
        send_pkt(4, 15, 15, 64'h2000, 1'b1);
        check("full_free", 64'(free_words), 64'd0);
        send_pkt(6, 1, 1, 64'h3000, 1'b0);
        exp_cnt++; exp_pulses++;
        settle_drops("full");
        check("full_free2", 64'(free_words), 64'd0);
        check("stall_vld", 64'(out_vld), 64'd1);
        check("stall_sop", 64'(out_sop), 64'd1);
        check("stall_data", out_data, q[0].data);
        out_ready = 1'b1;
        wait_drain("drain");
        check("drain_free", 64'(free_words), 64'd32);

        // Abort mid-payload, then a good L=2 packet
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b0, mk_hdr(7, 1, 6));
        drive(1'b0, 1'b1, 1'b0, 64'h400);
        drive(1'b0, 1'b1, 1'b0, 64'h401);
        send_pkt(8, 2, 2, 64'h500, 1'b1);
        exp_cnt++; exp_pulses++;
        wait_drain("abort");
        settle_drops("abort");

        // Reset while a packet is waiting to be read
        out_ready = 1'b0;
        send_pkt(9, 3, 3, 64'h600, 1'b1);
        check("prerst_vld", 64'(out_vld), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_vld", 64'(out_vld), 64'd0);
        check("midrst_free", 64'(free_words), 64'd32);
        check("midrst_cnt", 64'(drop_cnt), 64'd0);
        q.delete();
        exp_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_pkt(10, 2, 2, 64'h700, 1'b1);
        wait_drain("postrst");
        settle_drops("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
